// File: rtl/pipe_adder.sv
// Pipelined carry-chain adder/subtractor. The operands are cut into CHUNK-bit
// slices; each slice is added in its own register stage and the carry ripples
// from one stage to the next. A valid/ready handshake lets the consumer stall
// the whole pipeline, and status flags are produced alongside the final sum.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_width_check
        $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
    end

    // Ripple chain of single-bit full adders over one slice.
    // Returns {carry out, carry into slice MSB, slice sum}.
    function automatic logic [CHUNK+1:0] add_slice(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK-1:0] s;
        logic             c;
        logic             c_top;
        s     = '0;
        c     = ci;
        c_top = ci;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_top = c;
            end
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, c_top, s};
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    // Per-stage registered state, indexed by stage number.
    logic             vld_p   [STAGES];
    logic             carry_p [STAGES];
    logic [WIDTH-1:0] sum_p   [STAGES];
    logic [WIDTH-1:0] a_p     [STAGES];
    logic [WIDTH-1:0] b_p     [STAGES];

    // What each stage consumes: stage 0 takes the ports, stage k takes stage k-1.
    logic             v_src   [STAGES];
    logic             c_src   [STAGES];
    logic [WIDTH-1:0] s_src   [STAGES];
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] b_src   [STAGES];

    logic ovf_q;
    logic zero_q;

    // The whole pipeline freezes only when a finished result is refused.
    assign out_valid = vld_p[STAGES-1];
    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance;

    // Subtraction is A + ~B + 1; the +1 enters as stage 0 carry-in.
    assign b_eff = sub ? ~b : b;

    assign v_src[0] = in_valid;
    assign c_src[0] = sub;
    assign s_src[0] = '0;
    assign a_src[0] = a;
    assign b_src[0] = b_eff;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign v_src[k] = vld_p[k-1];
        assign c_src[k] = carry_p[k-1];
        assign s_src[k] = sum_p[k-1];
        assign a_src[k] = a_p[k-1];
        assign b_src[k] = b_p[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK+1:0] r;
        logic [WIDTH-1:0] s_next;
        logic             vld_q;
        logic             carry_q;
        logic [WIDTH-1:0] sum_q;

        assign r = add_slice(a_src[k][k*CHUNK +: CHUNK],
                             b_src[k][k*CHUNK +: CHUNK],
                             c_src[k]);

        // Splice this stage's slice into the sum completed by earlier stages.
        always_comb begin
            s_next = s_src[k];
            s_next[k*CHUNK +: CHUNK] = r[CHUNK-1:0];
        end

        // Stage register; bubbles move the valid bit but leave data untouched.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                vld_q <= v_src[k];
                if (v_src[k]) begin
                    carry_q <= r[CHUNK+1];
                    sum_q   <= s_next;
                end
            end
        end

        assign vld_p[k]   = vld_q;
        assign carry_p[k] = carry_q;
        assign sum_p[k]   = sum_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Carry the operand slices still waiting for later stages.
            always_ff @(posedge clk) begin
                if (advance && v_src[k]) begin
                    a_q <= a_src[k];
                    b_q <= b_src[k];
                end
            end

            assign a_p[k] = a_q;
            assign b_p[k] = b_q;
        end

        if (k == STAGES - 1) begin : g_tail
            // Flags derived from the top slice, captured with the final sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance && v_src[k]) begin
                    ovf_q  <= r[CHUNK+1] ^ r[CHUNK];
                    zero_q <= (s_next == '0);
                end
            end
        end
    end

    assign sum      = sum_p[STAGES-1];
    assign carry    = carry_p[STAGES-1];
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed corner cases on a 16/4 instance plus random
// traffic with random backpressure on 8/8, 16/4, 32/8 and 32/1 instances.
module tb_pipe_adder;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mon_on = 1'b0;

    logic        in_valid  [N];
    logic        out_ready [N];
    logic        sub       [N];
    logic [31:0] a         [N];
    logic [31:0] b         [N];
    logic        in_ready  [N];
    logic        out_valid [N];
    logic        carry     [N];
    logic        overflow  [N];
    logic        zero      [N];
    logic [7:0]  sum0;
    logic [15:0] sum1;
    logic [31:0] sum2;
    logic [31:0] sum3;
    logic [31:0] sum_w     [N];

    logic [34:0] exp_q [N][$];
    logic        held     [N];
    logic [34:0] held_val [N];

    int n_vec = 0;
    int n_err = 0;

    assign sum_w[0] = {24'b0, sum0};
    assign sum_w[1] = {16'b0, sum1};
    assign sum_w[2] = sum2;
    assign sum_w[3] = sum3;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(8), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0][7:0]), .b(b[0][7:0]), .sub(sub[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum0), .carry(carry[0]),
        .overflow(overflow[0]), .zero(zero[0]));

    pipe_adder #(.WIDTH(16), .CHUNK(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1][15:0]), .b(b[1][15:0]), .sub(sub[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum1), .carry(carry[1]),
        .overflow(overflow[1]), .zero(zero[1]));

    pipe_adder #(.WIDTH(32), .CHUNK(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .sub(sub[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum2), .carry(carry[2]),
        .overflow(overflow[2]), .zero(zero[2]));

    pipe_adder #(.WIDTH(32), .CHUNK(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a[3]), .b(b[3]), .sub(sub[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .sum(sum3), .carry(carry[3]),
        .overflow(overflow[3]), .zero(zero[3]));

    function automatic int w_of(input int i);
        case (i)
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    // Reference: plain unsigned/signed integer arithmetic, result {zero, ovf, carry, sum}.
    function automatic logic [34:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic s);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ux   = longint'({32'b0, x}) & m;
        longint uy   = longint'({32'b0, y}) & m;
        longint sx   = (ux >= half) ? ux - (m + 1) : ux;
        longint sy   = (uy >= half) ? uy - (m + 1) : uy;
        longint r;
        longint sr;
        logic   c;
        logic   ov;
        logic [31:0] r32;
        if (s) begin
            r  = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy;
            c  = (r > m);
            sr = sx + sy;
        end
        r   = r & m;
        ov  = (sr > half - 1) || (sr < -half);
        r32 = 32'(r);
        return {(r == 0), ov, c, r32};
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'd1 << (w - 1);
            3:       return mask >> 1;
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted operands, compare delivered results, check holds.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                exp_q[i].delete();
                held[i] = 1'b0;
            end else if (mon_on) begin
                if (held[i])
                    check("hold", 64'({out_valid[i], zero[i], overflow[i], carry[i], sum_w[i]}),
                          64'({1'b1, held_val[i]}));
                check("in_ready", 64'(in_ready[i]), 64'(!(out_valid[i] && !out_ready[i])));
                if (in_valid[i] && in_ready[i])
                    exp_q[i].push_back(model(w_of(i), a[i], b[i], sub[i]));
                if (out_valid[i] && out_ready[i]) begin
                    check("queue", 64'(exp_q[i].size() > 0), 64'(1));
                    if (exp_q[i].size() > 0)
                        check("result", 64'({zero[i], overflow[i], carry[i], sum_w[i]}),
                              64'(exp_q[i].pop_front()));
                end
                held[i]     = out_valid[i] && !out_ready[i];
                held_val[i] = {zero[i], overflow[i], carry[i], sum_w[i]};
            end
        end
    end

    // One operand into the 16/4 instance with exact latency and constant result checks.
    task automatic op1(input logic [15:0] x, input logic [15:0] y, input logic s,
                       input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        in_valid[1] = 1'b1;
        a[1] = {16'b0, x};
        b[1] = {16'b0, y};
        sub[1] = s;
        tick();
        in_valid[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("latency", 64'(out_valid[1]), 64'(i == 3));
            if (i < 3) tick();
        end
        check("dsum", 64'(sum_w[1]), 64'(es));
        check("dflags", 64'({carry[1], overflow[1], zero[1]}), 64'({ec, eo, ez}));
        tick();
    endtask

    initial begin
        int cnt;
        int first;
        int last;
        logic [31:0] s0;

        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b1;
            sub[i] = 1'b0;
            a[i] = '0;
            b[i] = '0;
            held[i] = 1'b0;
            held_val[i] = '0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check("rst_valid", 64'(out_valid[i]), 64'(0));
            check("rst_out", 64'({carry[i], overflow[i], zero[i], sum_w[i]}), 64'(0));
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) check("rst_ready", 64'(in_ready[i]), 64'(1));
        mon_on = 1'b1;

        // Directed corners
        op1(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        op1(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op1(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op1(16'h0001, 16'h7FFF, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream of 8
        cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            in_valid[1] = (c < 8);
            a[1] = 32'(c);
            b[1] = 32'h0000_7FFF;
            sub[1] = 1'(c & 1);
            tick();
            if (out_valid[1]) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        in_valid[1] = 1'b0;
        check("b2b_count", 64'(cnt), 64'(8));
        check("b2b_contig", 64'(last - first), 64'(7));
        check("b2b_first", 64'(first), 64'(3));

        // Backpressure with a full pipeline
        out_ready[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid[1] = 1'b1;
            a[1] = $urandom;
            b[1] = $urandom;
            sub[1] = 1'($urandom_range(0, 1));
            tick();
        end
        a[1] = $urandom;
        b[1] = $urandom;
        s0 = sum_w[1];
        check("stall_valid", 64'(out_valid[1]), 64'(1));
        repeat (5) begin
            check("stall_ready", 64'(in_ready[1]), 64'(0));
            check("stall_sum", 64'(sum_w[1]), 64'(s0));
            tick();
        end
        out_ready[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        repeat (10) tick();
        check("stall_drain", 64'(exp_q[1].size()), 64'(0));

        // Asynchronous reset with 3 operations in flight
        for (int c = 0; c < 3; c++) begin
            in_valid[1] = 1'b1;
            a[1] = 32'h0000_1000 + 32'(c);
            b[1] = 32'h0000_0100;
            sub[1] = 1'b0;
            tick();
        end
        in_valid[1] = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("flush_valid", 64'(out_valid[1]), 64'(0));
        check("flush_sum", 64'(sum_w[1]), 64'(0));
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (4) begin
            tick();
            check("flush_none", 64'(out_valid[1]), 64'(0));
        end
        op1(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        // Random traffic with random backpressure on all instances
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                in_valid[i] = ($urandom_range(0, 3) != 0);
                a[i] = pick(w_of(i));
                b[i] = pick(w_of(i));
                sub[i] = 1'($urandom_range(0, 1));
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (40) tick();
        for (int i = 0; i < N; i++) check("drain", 64'(exp_q[i].size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
